// File: rtl/nw_pipefifo_pkg.sv
// Shared types and constants for the pipelined FIFO slice.
// Imported by the interface, the pointer incrementer and the FIFO top.
package nw_pipefifo_pkg;

  localparam int unsigned FLIT_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // A single-entry buffer still needs a one-bit pointer to index its array.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nw_pipefifo_if.sv
// Producer/consumer bundle of the pipelined FIFO.
// The master side drives push/pop/data_in; the FIFO is the slave.
interface nw_pipefifo_if
  import nw_pipefifo_pkg::*;
#(
  parameter int unsigned WIDTH = $bits(flit_t),
  parameter int unsigned DEPTH = FIFO_DEPTH
) ();

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic             valid;
  logic [CW-1:0]    count;
  logic             err;

  modport master (
    output push, pop, data_in,
    input  data_out, ready, valid, count, err
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, ready, valid, count, err
  );

endinterface

// File: rtl/nw_pipefifo_wrap_ptr.sv
// Modulo-DEPTH pointer incrementer; wraps DEPTH-1 -> 0 for any DEPTH,
// not only powers of two.
module nw_wrap_ptr
  import nw_pipefifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PW   = ptr_w(DEPTH)
) (
  input  logic [PW-1:0] ptr,
  input  logic          inc,
  output logic [PW-1:0] nxt
);

  always_comb begin
    nxt = ptr;
    if (inc) begin
      nxt = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/nw_pipefifo.sv
// Circular-buffer FIFO with optional fall-through when empty and a sticky
// protocol-error flag for pushes while full or pops while empty.
module nw_pipefifo
  import nw_pipefifo_pkg::*;
#(
  parameter int unsigned WIDTH  = $bits(flit_t),
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned BYPASS = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  nw_pipefifo_if.slave  bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic     empty, full, bypass_empty;
  logic     valid, ready;
  logic     push_ok, pop_ok, passthru;
  logic     wr_inc, rd_inc;
  fifo_op_e op;

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CW'(DEPTH));
    bypass_empty = (BYPASS != 0) && empty;

    valid = bypass_empty ? bus.push : !empty;
    ready = !full || (bus.pop && valid);

    push_ok  = bus.push && ready;
    pop_ok   = bus.pop && valid;
    // An empty fall-through FIFO hands the word straight to the consumer
    // when both sides fire, so neither pointer nor count moves.
    passthru = bypass_empty && push_ok && pop_ok;

    op     = fifo_op_e'({pop_ok && !passthru, push_ok && !passthru});
    wr_inc = (op == OP_PUSH) || (op == OP_BOTH);
    rd_inc = (op == OP_POP)  || (op == OP_BOTH);

    count_d = count_q;
    case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    err_d = err_q || (bus.push && !ready) || (bus.pop && !valid);
  end

  nw_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .ptr (wr_ptr_q),
    .inc (wr_inc),
    .nxt (wr_ptr_d)
  );

  nw_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .ptr (rd_ptr_q),
    .inc (rd_inc),
    .nxt (rd_ptr_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; stale words are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (rst_n && wr_inc) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.valid    = valid;
  assign bus.ready    = ready;
  assign bus.data_out = bypass_empty ? bus.data_in : mem_q[rd_ptr_q];
  assign bus.count    = count_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_nw_pipefifo.sv
// Directed bench for nw_pipefifo: registered DEPTH=4, fall-through DEPTH=4
// and registered DEPTH=3 instances share one clock and reset.
module tb_nw_pipefifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nw_pipefifo_if #(.WIDTH(32), .DEPTH(4)) b4 ();
  nw_pipefifo_if #(.WIDTH(32), .DEPTH(4)) bb ();
  nw_pipefifo_if #(.WIDTH(32), .DEPTH(3)) b3 ();

  nw_pipefifo #(.WIDTH(32), .DEPTH(4), .BYPASS(0)) u_d4 (
    .clk (clk), .rst_n (rst_n), .bus (b4.slave));
  nw_pipefifo #(.WIDTH(32), .DEPTH(4), .BYPASS(1)) u_byp (
    .clk (clk), .rst_n (rst_n), .bus (bb.slave));
  nw_pipefifo #(.WIDTH(32), .DEPTH(3), .BYPASS(0)) u_d3 (
    .clk (clk), .rst_n (rst_n), .bus (b3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    b4.push = 1'b0; b4.pop = 1'b0; b4.data_in = '0;
    bb.push = 1'b0; bb.pop = 1'b0; bb.data_in = '0;
    b3.push = 1'b0; b3.pop = 1'b0; b3.data_in = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_count", 32'(b4.count), 32'd0);
    chk("rst_valid", 32'(b4.valid), 32'd0);
    chk("rst_err",   32'(b4.err),   32'd0);
    chk("rst_ready", 32'(b4.ready), 32'd1);
    chk("rst_byp_valid", 32'(bb.valid), 32'd0);

    // Fill DEPTH=4, then drain in order
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); b4.push = 1'b1; b4.data_in = 32'hA1 + 32'(i); #1;
      chk("fill_ready", 32'(b4.ready), 32'd1);
    end
    @(negedge clk); b4.push = 1'b0; #1;
    chk("full_count", 32'(b4.count), 32'd4);
    chk("full_ready", 32'(b4.ready), 32'd0);
    chk("full_valid", 32'(b4.valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); b4.pop = 1'b1; #1;
      chk("drain_data",  b4.data_out, 32'hA1 + 32'(i));
      chk("drain_valid", 32'(b4.valid), 32'd1);
    end
    @(negedge clk); b4.pop = 1'b0; #1;
    chk("drain_count", 32'(b4.count), 32'd0);
    chk("drain_valid_end", 32'(b4.valid), 32'd0);
    chk("drain_err", 32'(b4.err), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); b4.push = 1'b1; b4.data_in = 32'h11 + 32'(i);
    end
    @(negedge clk); b4.push = 1'b1; b4.pop = 1'b1; b4.data_in = 32'hB5; #1;
    chk("both_ready", 32'(b4.ready), 32'd1);
    chk("both_head",  b4.data_out, 32'h11);
    @(negedge clk); b4.push = 1'b0; b4.pop = 1'b0; #1;
    chk("both_count", 32'(b4.count), 32'd4);
    chk("both_err",   32'(b4.err),   32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); b4.pop = 1'b1; #1;
      chk("both_drain", b4.data_out, (i == 3) ? 32'hB5 : 32'h12 + 32'(i));
    end
    @(negedge clk); b4.pop = 1'b0; #1;
    chk("both_count_end", 32'(b4.count), 32'd0);

    // Push while full without pop: dropped, sticky err
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); b4.push = 1'b1; b4.data_in = 32'h21 + 32'(i);
    end
    @(negedge clk); b4.push = 1'b1; b4.data_in = 32'hE0; #1;
    chk("ovf_ready", 32'(b4.ready), 32'd0);
    chk("ovf_err_before", 32'(b4.err), 32'd0);
    @(negedge clk); b4.push = 1'b0; #1;
    chk("ovf_count", 32'(b4.count), 32'd4);
    chk("ovf_err", 32'(b4.err), 32'd1);
    @(negedge clk); #1;
    chk("ovf_err_sticky", 32'(b4.err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); b4.pop = 1'b1; #1;
      chk("ovf_drain", b4.data_out, 32'h21 + 32'(i));
    end
    @(negedge clk); b4.pop = 1'b0; #1;
    chk("ovf_count_end", 32'(b4.count), 32'd0);
    chk("ovf_err_still", 32'(b4.err), 32'd1);

    // Reset mid-operation at count=2
    @(negedge clk); b4.push = 1'b1; b4.data_in = 32'h31;
    @(negedge clk); b4.push = 1'b1; b4.data_in = 32'h32;
    @(negedge clk); b4.push = 1'b0; #1;
    chk("pre_rst_count", 32'(b4.count), 32'd2);
    @(negedge clk); rst_n = 1'b0; b4.push = 1'b1; b4.pop = 1'b1; b4.data_in = 32'hEE;
    @(negedge clk); rst_n = 1'b1; b4.push = 1'b0; b4.pop = 1'b0; #1;
    chk("mid_rst_count", 32'(b4.count), 32'd0);
    chk("mid_rst_valid", 32'(b4.valid), 32'd0);
    chk("mid_rst_err",   32'(b4.err),   32'd0);
    @(negedge clk); b4.push = 1'b1; b4.data_in = 32'hD9;
    @(negedge clk); b4.push = 1'b0; #1;
    chk("post_rst_count", 32'(b4.count), 32'd1);
    chk("post_rst_head",  b4.data_out, 32'hD9);
    @(negedge clk); b4.pop = 1'b1;
    @(negedge clk); b4.pop = 1'b0; #1;
    chk("post_rst_empty", 32'(b4.count), 32'd0);

    // Fall-through: push+pop when empty passes through without storing
    @(negedge clk); bb.push = 1'b1; bb.pop = 1'b1; bb.data_in = 32'hC7; #1;
    chk("byp_valid", 32'(bb.valid), 32'd1);
    chk("byp_data",  bb.data_out, 32'hC7);
    @(negedge clk); bb.push = 1'b0; bb.pop = 1'b0; #1;
    chk("byp_count", 32'(bb.count), 32'd0);
    chk("byp_valid_after", 32'(bb.valid), 32'd0);
    chk("byp_err", 32'(bb.err), 32'd0);
    @(negedge clk); bb.push = 1'b1; bb.data_in = 32'hC8; #1;
    chk("byp_push_valid", 32'(bb.valid), 32'd1);
    chk("byp_push_data",  bb.data_out, 32'hC8);
    @(negedge clk); bb.push = 1'b0; bb.data_in = 32'h0; #1;
    chk("byp_stored_count", 32'(bb.count), 32'd1);
    chk("byp_stored_data",  bb.data_out, 32'hC8);
    @(negedge clk); bb.pop = 1'b1;
    @(negedge clk); bb.pop = 1'b0; #1;
    chk("byp_drained", 32'(bb.count), 32'd0);

    // DEPTH=3: fill to full, then stream 1..10 through with wrapping pointers
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); b3.push = 1'b1; b3.data_in = 32'h41 + 32'(i);
    end
    @(negedge clk); b3.push = 1'b0; #1;
    chk("d3_full_count", 32'(b3.count), 32'd3);
    chk("d3_full_ready", 32'(b3.ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); b3.pop = 1'b1; #1;
      chk("d3_drain", b3.data_out, 32'h41 + 32'(i));
    end
    @(negedge clk); b3.pop = 1'b0; b3.push = 1'b1; b3.data_in = 32'd1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      b3.pop = 1'b1;
      b3.push = (k < 10);
      b3.data_in = 32'(k + 1);
      #1;
      chk("d3_stream", b3.data_out, 32'(k));
    end
    @(negedge clk); b3.push = 1'b0; b3.pop = 1'b0; #1;
    chk("d3_count_end", 32'(b3.count), 32'd0);
    chk("d3_err", 32'(b3.err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nw_pipefifo.md
NW_PIPEFIFO -- requirements
Module: nw_pipefifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries, legal range 1..64.
REQ-003 SHALL have parameter BYPASS, default 0; 1 = fall-through when empty, 0 = registered output.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port push  input  1  write data_in this cycle.
REQ-007 SHALL have port pop  input  1  consume head entry this cycle.
REQ-008 SHALL have port data_in  input  WIDTH  write data.
REQ-009 SHALL have port data_out  output  WIDTH  head entry; don't-care while valid=0.
REQ-010 SHALL have port ready  output  1  push will be accepted on next edge.
REQ-011 SHALL have port valid  output  1  data_out holds a valid entry.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  entries stored.
REQ-013 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL implement a circular buffer of DEPTH entries with read/write pointers wrapping DEPTH-1 -> 0; DEPTH need not be a power of two.
REQ-015 SHALL drive ready = (count < DEPTH) || (pop && valid), combinationally.
REQ-016 SHALL, with BYPASS=0, drive valid = (count != 0) and data_out = entry at read pointer; push-to-valid latency 1 cycle.
REQ-017 SHALL, with BYPASS=1 and count=0, drive valid = push and data_out = data_in in the same cycle (latency 0).
REQ-018 SHALL, with BYPASS=1, count=0, push=1, pop=1, pass the word through without storing it; count stays 0.
REQ-019 SHALL, on accepted push only, write data_in at write pointer, advance write pointer, count+1.
REQ-020 SHALL, on accepted pop only, advance read pointer, count-1.
REQ-021 SHALL, on simultaneous accepted push and pop with count>0, advance both pointers and hold count; legal at count=DEPTH.
REQ-022 SHALL ignore push when ready=0 (no write, no pointer/count change) and set err.
REQ-023 SHALL ignore pop when valid=0 (no pointer/count change) and set err.
REQ-024 SHALL keep err at 1 until reset; err SHALL NOT stop normal operation.
REQ-025 SHALL, with DEPTH=1 and BYPASS=0, be cycle-equivalent to the existing single-entry interlocked pipeline register on legal traffic.
REQ-026 SHALL never let count exceed DEPTH nor go below 0.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set count=0, both pointers=0, err=0; valid=0 follows (BYPASS=1: valid=push).
REQ-028 SHALL discard all stored entries on reset asserted mid-operation; storage array is not cleared.
REQ-029 SHALL ignore push/pop during the reset cycle.

Structure
REQ-030 SHALL take flit_t and shared width/depth constants from the common types package; no local typedefs.
REQ-031 SHALL use one sub-module nw_wrap_ptr (parametrised modulo-DEPTH pointer incrementer), instanced for read and write pointers.
REQ-032 SHALL contain no $fatal; protocol errors are reported only via err.

Verification
REQ-033 SHALL test DEPTH=4, BYPASS=0: push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> count=4, ready=0; then pop 4 cycles -> data_out 0xA1..0xA4 in order, count=0, valid=0.
REQ-034 SHALL test full with simultaneous push 0xB5 and pop -> accepted, count stays 4, 0xB5 appears after the 4th pop; err=0.
REQ-035 SHALL test push at count=4 without pop -> data dropped, count=4, err=1 next cycle and stays 1.
REQ-036 SHALL test BYPASS=1, empty, push 0xC7 with pop -> data_out=0xC7, valid=1 same cycle, count=0 after edge.
REQ-037 SHALL test DEPTH=3: 10 push/pop pairs with data 1..10 -> output order 1..10, pointer wrap exercised, no err.
REQ-038 SHALL test reset asserted at count=2 -> next cycle count=0, valid=0, err=0; subsequent push 0xD9 emerges first.
